// File: rtl/adder_accumulator_if.sv
// Handshake and adder-side signals of the accumulator stage.
// master drives commands and the adder result; slave is the accumulator.
interface adder_accumulator_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_operand;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH:0]   add_sum;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_acc;
    logic             out_carry;

    modport master (
        output in_valid, in_op, in_operand, out_ready, add_sum,
        input  in_ready, add_a, add_b, out_valid, out_acc, out_carry
    );

    modport slave (
        input  in_valid, in_op, in_operand, out_ready, add_sum,
        output in_ready, add_a, add_b, out_valid, out_acc, out_carry
    );
endinterface

// File: rtl/adder_accumulator.sv
// Accumulator stage behind a slow combinational adder.
// Holds adder inputs for SETTLE_CYCLES before capturing the sum.
module adder_accumulator #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input logic               clk,
    input logic               rst_n,
    adder_accumulator_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opnd_r;
    logic             carry;
    logic [7:0]       cnt;
    logic             accept;
    logic             sample;

    assign accept = (state == IDLE) && bus.in_valid;
    assign sample = (state == SETTLE) && (cnt == 8'd0);

    // State register; reset abandons any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: ADD waits out the carry chain, everything else answers at once.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_op == OP_ADD) begin
                        state_next = SETTLE;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            SETTLE: begin
                if (cnt == 8'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs come from state and registers only, never from inputs.
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == RESP);
        bus.out_acc   = acc;
        bus.out_carry = carry;
        bus.add_a     = acc;
        bus.add_b     = opnd_r;
    end

    // Datapath; acc and opnd_r stay frozen in SETTLE so the adder sees stable inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            opnd_r <= '0;
            carry  <= 1'b0;
            cnt    <= 8'd0;
        end else if (accept) begin
            opnd_r <= bus.in_operand;
            unique case (bus.in_op)
                OP_LOAD: begin
                    acc   <= bus.in_operand;
                    carry <= 1'b0;
                end
                OP_ADD: begin
                    cnt <= CNT_INIT;
                end
                OP_CLEAR: begin
                    acc   <= '0;
                    carry <= 1'b0;
                end
                OP_NOP: begin
                end
                default: begin
                end
            endcase
        end else if (sample) begin
            acc   <= bus.add_sum[WIDTH-1:0];
            carry <= bus.add_sum[WIDTH];
        end else if (state == SETTLE) begin
            cnt <= cnt - 8'd1;
        end
    end
endmodule

// File: tb/tb_adder_accumulator.sv
// Bench for adder_accumulator with a slow adder model.
// Compares the DUT against an arithmetic reference of the command set.
`timescale 1ns/1ps
module tb_adder_accumulator;
    localparam int WIDTH  = 4;
    localparam int SETTLE = 3;
    localparam int MODV   = 1 << WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    adder_accumulator_if #(.WIDTH(WIDTH)) bus();

    adder_accumulator #(
        .WIDTH(WIDTH),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Adder model: in slow mode the sum is wrong until 29 ns after a/b change,
    // so only a capture on the third edge after the change sees a good value.
    logic slow = 1'b0;
    time  t_chg = 0;
    always @(bus.add_a or bus.add_b) t_chg = $time;
    always begin
        logic [WIDTH:0] s;
        #1;
        s = {1'b0, bus.add_a} + {1'b0, bus.add_b};
        if (slow && ($time - t_chg < 29)) bus.add_sum = ~s;
        else bus.add_sum = s;
    end

    int ref_acc   = 0;
    int ref_carry = 0;

    task automatic ref_apply(input int op, input int v);
        case (op)
            0: begin ref_acc = v; ref_carry = 0; end
            1: begin
                ref_carry = (ref_acc + v >= MODV) ? 1 : 0;
                ref_acc   = (ref_acc + v) % MODV;
            end
            2: begin ref_acc = 0; ref_carry = 0; end
            default: ;
        endcase
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] v);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL issue_timeout in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid   = 1'b1;
        bus.in_op      = op;
        bus.in_operand = v;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        ref_apply(int'(op), int'(v));
    endtask

    task automatic await_resp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.out_valid !== 1'b1 && lat < 100);
    endtask

    task automatic release_resp();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.out_acc !== 4'd0 || bus.out_carry !== 1'b0 ||
            bus.add_a !== 4'd0 || bus.add_b !== 4'd0) begin
            errors++;
            $display("FAIL reset rdy=%b vld=%b acc=%0d c=%b a=%0d b=%0d required 1 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_acc,
                     bus.out_carry, bus.add_a, bus.add_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_add();
        int lat;
        issue(2'b00, 4'd9);
        await_resp(lat);
        release_resp();
        issue(2'b01, 4'd9);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_settle rdy=%b vld=%b required 0 0",
                     bus.in_ready, bus.out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.out_acc !== 4'd0 || bus.out_carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_async rdy=%b vld=%b acc=%0d c=%b required 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_acc, bus.out_carry);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ref_acc = 0;
        ref_carry = 0;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_acc !== 4'd0) begin
            errors++;
            $display("FAIL reset_discard vld=%b acc=%0d required 0 0",
                     bus.out_valid, bus.out_acc);
        end
    endtask

    task automatic test_load_add();
        int lat;
        issue(2'b00, 4'd5);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_acc !== 4'd5) begin
            errors++;
            $display("FAIL load_resp vld=%b acc=%0d required 1 5",
                     bus.out_valid, bus.out_acc);
        end
        release_resp();
        issue(2'b01, 4'd7);
        for (int i = 0; i < SETTLE; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 ||
                bus.add_a !== 4'd5 || bus.add_b !== 4'd7) begin
                errors++;
                $display("FAIL add_hold[%0d] vld=%b rdy=%b a=%0d b=%0d required 0 0 5 7",
                         i, bus.out_valid, bus.in_ready, bus.add_a, bus.add_b);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_acc !== 4'd12 ||
            bus.out_carry !== 1'b0) begin
            errors++;
            $display("FAIL add_resp vld=%b acc=%0d c=%b required 1 12 0",
                     bus.out_valid, bus.out_acc, bus.out_carry);
        end
        release_resp();
        lat = 0;
    endtask

    task automatic test_overflow();
        int lat;
        issue(2'b00, 4'd9);
        await_resp(lat);
        release_resp();
        issue(2'b01, 4'd9);
        await_resp(lat);
        checks++;
        if (lat != SETTLE + 1 || bus.out_acc !== 4'd2 || bus.out_carry !== 1'b1) begin
            errors++;
            $display("FAIL overflow lat=%0d acc=%0d c=%b required %0d 2 1",
                     lat, bus.out_acc, bus.out_carry, SETTLE + 1);
        end
        release_resp();
        issue(2'b11, 4'd4);
        await_resp(lat);
        checks++;
        if (lat != 1 || bus.out_acc !== 4'd2 || bus.out_carry !== 1'b1) begin
            errors++;
            $display("FAIL nop_keep lat=%0d acc=%0d c=%b required 1 2 1",
                     lat, bus.out_acc, bus.out_carry);
        end
        release_resp();
        issue(2'b10, 4'd6);
        await_resp(lat);
        checks++;
        if (lat != 1 || bus.out_acc !== 4'd0 || bus.out_carry !== 1'b0) begin
            errors++;
            $display("FAIL clear lat=%0d acc=%0d c=%b required 1 0 0",
                     lat, bus.out_acc, bus.out_carry);
        end
        release_resp();
    endtask

    task automatic test_back_pressure();
        int lat;
        issue(2'b00, 4'd3);
        await_resp(lat);
        release_resp();
        issue(2'b01, 4'd4);
        await_resp(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_acc !== 4'd7 ||
                bus.out_carry !== 1'b0 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d] vld=%b acc=%0d c=%b rdy=%b required 1 7 0 0",
                         i, bus.out_valid, bus.out_acc, bus.out_carry, bus.in_ready);
            end
            if (i == 4) begin
                bus.in_valid   = 1'b1;
                bus.in_op      = 2'b00;
                bus.in_operand = 4'd15;
            end
            if (i == 6) bus.in_valid = 1'b0;
        end
        release_resp();
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.out_acc !== 4'd7) begin
            errors++;
            $display("FAIL bp_release rdy=%b vld=%b acc=%0d required 1 0 7",
                     bus.in_ready, bus.out_valid, bus.out_acc);
        end
    endtask

    task automatic test_settle();
        int lat;
        slow = 1'b1;
        issue(2'b00, 4'd6);
        await_resp(lat);
        release_resp();
        issue(2'b01, 4'd13);
        await_resp(lat);
        checks++;
        if (lat != SETTLE + 1 || bus.out_acc !== 4'd3 || bus.out_carry !== 1'b1) begin
            errors++;
            $display("FAIL settle_add lat=%0d acc=%0d c=%b required %0d 3 1",
                     lat, bus.out_acc, bus.out_carry, SETTLE + 1);
        end
        release_resp();
        issue(2'b01, 4'd2);
        await_resp(lat);
        checks++;
        if (bus.out_acc !== 4'd5 || bus.out_carry !== 1'b0) begin
            errors++;
            $display("FAIL settle_add2 acc=%0d c=%b required 5 0",
                     bus.out_acc, bus.out_carry);
        end
        release_resp();
    endtask

    task automatic test_random();
        int lat;
        int op;
        int v;
        int exp_lat;
        int mism;
        mism = 0;
        for (int i = 0; i < 200; i++) begin
            op = int'($urandom_range(0, 3));
            v  = int'($urandom_range(0, MODV - 1));
            issue(2'(op), 4'(v));
            await_resp(lat);
            exp_lat = (op == 1) ? SETTLE + 1 : 1;
            checks++;
            if (lat != exp_lat || int'(bus.out_acc) != ref_acc ||
                int'(bus.out_carry) != ref_carry) begin
                errors++;
                mism++;
                $display("FAIL random[%0d] op=%0d v=%0d lat=%0d acc=%0d c=%0d required %0d %0d %0d",
                         i, op, v, lat, bus.out_acc, bus.out_carry,
                         exp_lat, ref_acc, ref_carry);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            release_resp();
        end
        $display("random regression: 200 sequences, %0d mismatches", mism);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_op      = 2'b11;
        bus.in_operand = '0;
        bus.out_ready  = 1'b0;
        test_reset();
        test_reset_mid_add();
        test_load_add();
        test_overflow();
        test_back_pressure();
        test_settle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
